// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg: default geometry and shared constants for the register file.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_ADDR_WIDTH = 5;
    localparam int C_NUM_READ   = 2;
    localparam int C_ZERO_ADDR  = 0;

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ----------------------------------------------------------------------------
// regfile_rdport: one combinational read port with write-through bypass.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
    input  logic [2**ADDR_WIDTH-1:0]                 busy,
    input  logic [ADDR_WIDTH-1:0]                    ra,
    input  logic                                     wr_en,
    input  logic [ADDR_WIDTH-1:0]                    wa,
    input  logic [DATA_WIDTH-1:0]                    wd,
    input  logic                                     iss_en,
    input  logic [ADDR_WIDTH-1:0]                    ia,
    output logic [DATA_WIDTH-1:0]                    rd,
    output logic                                     rbusy
);

    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = ADDR_WIDTH'(C_ZERO_ADDR);

    logic w_bypass;
    logic w_iss_hit;
    logic w_is_zero;

    // wr_en arrives already qualified by nonzero address and reset release
    assign w_bypass  = wr_en && (wa == ra);
    assign w_iss_hit = iss_en && (ia == ra);
    assign w_is_zero = (ra == c_zero_addr);

    always_comb begin
        rd    = regs[ra];
        rbusy = busy[ra];
        if (w_is_zero) begin
            rd    = '0;
            rbusy = 1'b0;
        end else if (w_bypass) begin
            rd = wd;
            if (!w_iss_hit) begin
                rbusy = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp: multi-read-port register file with per-register busy scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int NUM_READ   = C_NUM_READ
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           regwrite,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic                           issue,
    input  logic [ADDR_WIDTH-1:0]          ia,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic [NUM_READ-1:0]            rbusy,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int                    c_depth     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = ADDR_WIDTH'(C_ZERO_ADDR);

    logic [c_depth-1:0][DATA_WIDTH-1:0] r_regs;
    logic [c_depth-1:0]                 r_busy;
    logic [ADDR_WIDTH:0]                r_busy_cnt;

    logic               w_wr_en;
    logic               w_iss_en;
    logic               w_byp_en;
    logic               w_inc;
    logic               w_dec;
    logic [c_depth-1:0] w_busy_next;

    assign w_wr_en  = regwrite && (wa != c_zero_addr);
    assign w_iss_en = issue && (ia != c_zero_addr);
    assign w_byp_en = w_wr_en && rst_n;

    // Issue is applied after the write clear so a same-address issue wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[wa] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[ia] = 1'b1;
        end
    end

    assign w_inc = w_iss_en && !r_busy[ia];
    assign w_dec = w_wr_en && r_busy[wa] && !(w_iss_en && (ia == wa));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs     <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[wa] <= wd;
            end
            r_busy     <= w_busy_next;
            r_busy_cnt <= r_busy_cnt + (ADDR_WIDTH+1)'(w_inc) - (ADDR_WIDTH+1)'(w_dec);
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rdport
        regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rdport (
            .regs   (r_regs),
            .busy   (r_busy),
            .ra     (ra[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .wr_en  (w_byp_en),
            .wa     (wa),
            .wd     (wd),
            .iss_en (w_iss_en),
            .ia     (ia),
            .rd     (rd[k*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy  (rbusy[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp: directed and randomized checks against an array-based model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        regwrite;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        issue;
    logic [4:0]  ia;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [5:0]  busy_cnt;

    logic         regwrite4;
    logic [4:0]   wa4;
    logic [63:0]  wd4;
    logic         issue4;
    logic [4:0]   ia4;
    logic [19:0]  ra4;
    logic [255:0] rd4;
    logic [3:0]   rbusy4;
    logic [5:0]   busy_cnt4;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .issue    (issue),
        .ia       (ia),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .busy_cnt (busy_cnt)
    );

    regfile_mp #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (5),
        .NUM_READ   (4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .regwrite (regwrite4),
        .wa       (wa4),
        .wd       (wd4),
        .issue    (issue4),
        .ia       (ia4),
        .ra       (ra4),
        .rd       (rd4),
        .rbusy    (rbusy4),
        .busy_cnt (busy_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Model state advances from the architectural rules, issue applied last.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            if (regwrite && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (issue && ia != 0) begin
                m_busy[ia] = 1'b1;
            end
        end
    end

    always @(negedge rst_n) model_clear();

    always @(negedge clk) begin
        int          pop;
        logic [4:0]  a;
        logic [31:0] exp_rd;
        bit          exp_rb;
        bit          byp;
        for (int k = 0; k < 2; k++) begin
            a      = ra[k*5 +: 5];
            byp    = rst_n && regwrite && wa != 0 && wa == a;
            exp_rd = !rst_n ? 32'h0 : (byp ? wd : m_regs[a]);
            exp_rb = !rst_n ? 1'b0 : ((byp && !(issue && ia == a)) ? 1'b0 : m_busy[a]);
            chk($sformatf("model_rd%0d", k), {32'h0, rd[k*32 +: 32]}, {32'h0, exp_rd});
            chk($sformatf("model_rbusy%0d", k), {63'h0, rbusy[k]}, {63'h0, exp_rb});
        end
        pop = 0;
        for (int i = 0; i < 32; i++) pop += int'(m_busy[i]);
        chk("model_busy_cnt", {58'h0, busy_cnt}, 64'(pop));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite = 1'b0;
        issue    = 1'b0;
        wa       = '0;
        ia       = '0;
        wd       = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        idle();
        ra        = '0;
        regwrite4 = 1'b0;
        wa4       = '0;
        wd4       = '0;
        issue4    = 1'b0;
        ia4       = '0;
        ra4       = '0;
        model_clear();

        // Reset suppresses bypass and busy
        step();
        regwrite = 1'b1; wa = 5'h03; wd = 32'h14; ra[4:0] = 5'h03;
        issue = 1'b1; ia = 5'h03;
        #1;
        chk("reset_bypass_rd0", {32'h0, rd[31:0]}, 64'h0);
        chk("reset_rbusy0", {63'h0, rbusy[0]}, 64'h0);
        step();
        idle();
        rst_n = 1'b1;
        ra = {5'h07, 5'h00};
        #1;
        chk("post_reset_rd", rd, 64'h0);
        chk("post_reset_rbusy", {62'h0, rbusy}, 64'h0);
        chk("post_reset_cnt", {58'h0, busy_cnt}, 64'h0);

        // Bypass then stored value
        step();
        regwrite = 1'b1; wa = 5'h03; wd = 32'h14; ra[4:0] = 5'h03;
        #1;
        chk("bypass_rd0", {32'h0, rd[31:0]}, 64'h14);
        step();
        idle();
        #1;
        chk("stored_rd0", {32'h0, rd[31:0]}, 64'h14);

        // Register zero ignores writes and issues
        regwrite = 1'b1; wa = 5'h00; wd = 32'hDEADBEEF; issue = 1'b1; ia = 5'h00;
        ra[4:0] = 5'h00;
        #1;
        chk("zero_bypass_rd0", {32'h0, rd[31:0]}, 64'h0);
        step();
        idle();
        #1;
        chk("zero_rd0", {32'h0, rd[31:0]}, 64'h0);
        chk("zero_rbusy0", {63'h0, rbusy[0]}, 64'h0);
        chk("zero_cnt", {58'h0, busy_cnt}, 64'h0);

        // Busy counting and clearing
        issue = 1'b1; ia = 5'h04;
        step();
        chk("cnt_after_i4", {58'h0, busy_cnt}, 64'd1);
        ia = 5'h05;
        step();
        chk("cnt_after_i5", {58'h0, busy_cnt}, 64'd2);
        ia = 5'h04;
        step();
        chk("cnt_reissue_i4", {58'h0, busy_cnt}, 64'd2);
        idle();
        regwrite = 1'b1; wa = 5'h04; wd = 32'h1d; ra[9:5] = 5'h04;
        #1;
        chk("bypass_rbusy1", {63'h0, rbusy[1]}, 64'h0);
        step();
        idle();
        #1;
        chk("cnt_after_w4", {58'h0, busy_cnt}, 64'd1);
        chk("rd1_reg4", {32'h0, rd[63:32]}, 64'h1d);
        chk("rbusy1_reg4", {63'h0, rbusy[1]}, 64'h0);

        // Same-cycle issue and write: issue wins the busy bit
        issue = 1'b1; ia = 5'h06; regwrite = 1'b1; wa = 5'h06; wd = 32'hA5;
        step();
        idle();
        ra[4:0] = 5'h06;
        #1;
        chk("iw_rd0", {32'h0, rd[31:0]}, 64'hA5);
        chk("iw_rbusy0", {63'h0, rbusy[0]}, 64'h1);
        chk("iw_cnt", {58'h0, busy_cnt}, 64'd2);

        // Fill 1..3, then a reset pulse between edges
        for (int n = 1; n <= 3; n++) begin
            regwrite = 1'b1; wa = 5'(n); wd = 32'h10 + 32'(n);
            issue = 1'b1; ia = 5'(n);
            step();
        end
        idle();
        ra = {5'h03, 5'h01};
        #1;
        chk("fill_rd0", {32'h0, rd[31:0]}, 64'h11);
        chk("fill_cnt", {58'h0, busy_cnt}, 64'd5);
        rst_n = 1'b0;
        #1;
        chk("pulse_rd", rd, 64'h0);
        chk("pulse_rbusy", {62'h0, rbusy}, 64'h0);
        chk("pulse_cnt", {58'h0, busy_cnt}, 64'h0);
        #1;
        rst_n = 1'b1;

        // Saturated scoreboard
        for (int n = 1; n < 32; n++) begin
            issue = 1'b1; ia = 5'(n);
            step();
        end
        chk("cnt_full", {58'h0, busy_cnt}, 64'd31);
        ia = 5'h07;
        step();
        chk("cnt_full_reissue", {58'h0, busy_cnt}, 64'd31);
        idle();
        regwrite = 1'b1; wa = 5'h07; wd = 32'h77;
        step();
        idle();
        chk("cnt_full_minus", {58'h0, busy_cnt}, 64'd30);

        // Wide, four-port instance
        regwrite4 = 1'b1; wa4 = 5'h03; wd4 = 64'hC0DE_0000_0000_0014;
        ra4 = {4{5'h03}};
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("w4_bypass_rd%0d", k), rd4[k*64 +: 64], 64'hC0DE_0000_0000_0014);
        step();
        regwrite4 = 1'b0; wd4 = '0;
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("w4_stored_rd%0d", k), rd4[k*64 +: 64], 64'hC0DE_0000_0000_0014);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            regwrite = $urandom_range(0, 1) == 1;
            issue    = $urandom_range(0, 9) < 4;
            wa       = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ia       = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd       = $urandom;
            for (int k = 0; k < 2; k++)
                ra[k*5 +: 5] = $urandom_range(0, 2) == 0 ? wa :
                               ($urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom));
            step();
        end
        rst_n = 1'b1;
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
